// File: rtl/dircc_mem_pkg.sv
// Shared definitions for the DIRCC memory copy master: default geometry and FSM state encoding.
package dircc_mem_pkg;

    localparam int DEFAULT_ADDR_W = 14;
    localparam int DEFAULT_DEPTH  = 10240;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        READ,
        RDATA,
        WRITE,
        FINISH
    } copy_state_t;

endpackage

// File: rtl/dircc_mem_copy_master.sv
// Avalon-MM master that copies a block of 32-bit words from src to dst, one
// read/write pair per word, after rejecting out-of-range or unsafely overlapping commands.
module dircc_mem_copy_master
    import dircc_mem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_WORD = {{ADDR_W{1'b0}}, 1'b1};

    copy_state_t       state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   src_end;
    logic [ADDR_W:0]   dst_end;
    logic              cmd_bad;

    // Sums are one bit wider than an address so the range checks cannot wrap.
    // A destination starting inside the source range would overwrite unread words
    // of an ascending copy, so that overlap is rejected; the downward case is safe.
    assign src_end = {1'b0, src_ptr} + remaining;
    assign dst_end = {1'b0, dst_ptr} + remaining;
    assign cmd_bad = (remaining > DEPTH_LIM) ||
                     (src_end > DEPTH_LIM) ||
                     (dst_end > DEPTH_LIM) ||
                     ((dst_ptr > src_ptr) && ({1'b0, dst_ptr} < src_end));

    // avm_writedata doubles as the holding register for the word in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_byteenable <= 4'b0000;
            avm_writedata  <= '0;
            src_ptr        <= '0;
            dst_ptr        <= '0;
            remaining      <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= len;
                        busy      <= 1'b1;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (cmd_bad) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (remaining == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FINISH;
                    end else begin
                        avm_read    <= 1'b1;
                        avm_address <= src_ptr;
                        state       <= READ;
                    end
                end
                READ: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        state    <= RDATA;
                    end
                end
                RDATA: begin
                    avm_writedata  <= avm_readdata;
                    avm_write      <= 1'b1;
                    avm_byteenable <= 4'b1111;
                    avm_address    <= dst_ptr;
                    state          <= WRITE;
                end
                WRITE: begin
                    if (!avm_waitrequest) begin
                        avm_write      <= 1'b0;
                        avm_byteenable <= 4'b0000;
                        src_ptr        <= src_ptr + 1'b1;
                        dst_ptr        <= dst_ptr + 1'b1;
                        remaining      <= remaining - 1'b1;
                        if (remaining != LAST_WORD) begin
                            avm_read    <= 1'b1;
                            avm_address <= src_ptr + 1'b1;
                            state       <= READ;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dircc_mem_copy_master.sv
// Self-checking bench for dircc_mem_copy_master: Avalon slave memory model with
// programmable stalls, table-driven and randomized copies checked against a word-level model.
module tb_dircc_mem_copy_master;
    import dircc_mem_pkg::*;

    localparam int AW      = DEFAULT_ADDR_W;
    localparam int DEPTH   = DEFAULT_DEPTH;
    localparam int TIMEOUT = 5000;

    typedef struct {
        int src;
        int dst;
        int len;
        int stalls;
        bit rnd;
        bit exp_err;
        int exp_busy;
    } vec_t;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] avm_address;
    logic          avm_read;
    logic          avm_write;
    logic [3:0]    avm_byteenable;
    logic [31:0]   avm_writedata;
    logic [31:0]   avm_readdata;
    logic          avm_waitrequest;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   ref_mem [DEPTH];
    bit            preload;
    int            fixed_stalls;
    bit            random_stalls;
    int            stall_cnt;
    int            rand_target;
    int            stab_viol;
    bit            stall_prev;
    logic [AW+37:0] saved_req;

    int n_checks;
    int n_fail;

    dircc_mem_copy_master #(
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .src_addr        (src_addr),
        .dst_addr        (dst_addr),
        .len             (len),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each request is stalled for a fixed or random number of cycles before acceptance.
    assign avm_waitrequest = (avm_read || avm_write) &&
                             (stall_cnt < (random_stalls ? rand_target : fixed_stalls));

    // Slave memory: read latency of one cycle, writes land on acceptance.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= $urandom;
            for (int i = 0; i < 4; i++) mem[i] <= 32'hA0 + i;
        end
        if (!(avm_read || avm_write)) begin
            stall_cnt <= 0;
        end else if (avm_waitrequest) begin
            stall_cnt <= stall_cnt + 1;
        end else begin
            stall_cnt   <= 0;
            rand_target <= $urandom_range(0, 2);
        end
        if (avm_read && !avm_waitrequest) avm_readdata <= mem[avm_address];
        if (avm_write && !avm_waitrequest) mem[avm_address] <= avm_writedata;
    end

    // Any change of the request lines across a stalled cycle counts as a violation.
    always @(posedge clk) begin
        if (stall_prev &&
            ({avm_read, avm_write, avm_address, avm_writedata, avm_byteenable} != saved_req))
            stab_viol <= stab_viol + 1;
        stall_prev <= (avm_read || avm_write) && avm_waitrequest;
        saved_req  <= {avm_read, avm_write, avm_address, avm_writedata, avm_byteenable};
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic bit modelRejects(input int s, input int d, input int l);
        return (s + l > DEPTH) || (d + l > DEPTH) || (d > s && d < s + l);
    endfunction

    function automatic int memDiffs();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    task automatic applyStimulus(input vec_t v, input string tag);
        int busy_n = 0, done_n = 0, err_n = 0, rd_n = 0, wr_n = 0;
        int both_n = 0, be_bad = 0, done_at = -1, err_at = -1, last_wr = -1;
        int stab0;
        int words;
        fixed_stalls  = v.stalls;
        random_stalls = v.rnd;
        @(negedge clk);
        src_addr = AW'(v.src);
        dst_addr = AW'(v.dst);
        len      = (AW+1)'(v.len);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stab0 = stab_viol;
        for (int cyc = 0; cyc < TIMEOUT; cyc++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = cyc;
            end
            if (error) begin
                err_n++;
                if (err_at < 0) err_at = cyc;
            end
            if (avm_read && avm_write) both_n++;
            if (avm_write && avm_byteenable != 4'b1111) be_bad++;
            if (avm_read && !avm_waitrequest) rd_n++;
            if (avm_write && !avm_waitrequest) begin
                wr_n++;
                last_wr = int'(avm_address);
            end
            if ((done_at >= 0 && cyc >= done_at + 3) || (err_at >= 0 && cyc >= err_at + 3)) break;
            @(negedge clk);
        end
        words = v.exp_err ? 0 : v.len;
        checkOutput({tag, " completed"}, (done_at >= 0 || err_at >= 0), 1);
        checkOutput({tag, " error pulses"}, err_n, v.exp_err);
        checkOutput({tag, " done pulses"}, done_n, !v.exp_err);
        if (v.exp_busy >= 0) checkOutput({tag, " busy cycles"}, busy_n, v.exp_busy);
        if (v.exp_err) checkOutput({tag, " error timing"}, err_at, 1);
        else           checkOutput({tag, " done timing"}, done_at, busy_n);
        checkOutput({tag, " read count"}, rd_n, words);
        checkOutput({tag, " write count"}, wr_n, words);
        checkOutput({tag, " read+write overlap"}, both_n, 0);
        checkOutput({tag, " byteenable"}, be_bad, 0);
        checkOutput({tag, " stall stability"}, stab_viol - stab0, 0);
        if (words > 0) checkOutput({tag, " last write addr"}, last_wr, v.dst + v.len - 1);
        for (int i = 0; i < words; i++) ref_mem[v.dst + i] = ref_mem[v.src + i];
        checkOutput({tag, " memory contents"}, memDiffs(), 0);
    endtask

    vec_t table_v [10];
    vec_t v;

    initial begin
        int wcnt;
        int bad_n;
        n_checks = 0;
        n_fail   = 0;
        stab_viol = 0;
        stall_prev = 1'b0;
        stall_cnt = 0;
        rand_target = 0;
        avm_readdata = '0;

        table_v[0] = '{0,     100,   4,  0, 1'b0, 1'b0, 13};
        table_v[1] = '{0,     120,   4,  2, 1'b0, 1'b0, 29};
        table_v[2] = '{5,     7,     0,  0, 1'b0, 1'b0, 1};
        table_v[3] = '{10200, 0,     41, 0, 1'b0, 1'b1, 1};
        table_v[4] = '{10200, 10200, 40, 0, 1'b0, 1'b0, 121};
        table_v[5] = '{0,     2,     4,  0, 1'b0, 1'b1, 1};
        table_v[6] = '{2,     0,     4,  0, 1'b0, 1'b0, 13};
        table_v[7] = '{0,     10239, 2,  0, 1'b0, 1'b1, 1};
        table_v[8] = '{50,    10239, 1,  0, 1'b0, 1'b0, 4};
        table_v[9] = '{0,     4,     4,  1, 1'b0, 1'b0, 21};

        reset_n = 1'b0;
        start = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len = '0;
        fixed_stalls = 0;
        random_stalls = 1'b0;
        preload = 1'b1;
        repeat (3) @(negedge clk);
        preload = 1'b0;
        checkOutput("reset outputs",
                    {busy, done, error, avm_read, avm_write, avm_address, avm_byteenable, avm_writedata}, 0);
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(table_v[i], $sformatf("vec%0d", i));
            if (i == 0)
                for (int k = 0; k < 4; k++)
                    checkOutput($sformatf("mem[%0d]", 100 + k), mem[100 + k], 32'hA0 + k);
        end

        $display("[TB] start strobe while busy must be ignored");
        fork
            applyStimulus('{0, 400, 3, 0, 1'b0, 1'b0, 10}, "ignore_start");
            begin
                repeat (4) @(negedge clk);
                src_addr = AW'(10000);
                dst_addr = AW'(0);
                len = (AW+1)'(100);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join

        $display("[TB] reset during second write");
        fixed_stalls = 0;
        random_stalls = 1'b0;
        @(negedge clk);
        src_addr = AW'(0);
        dst_addr = AW'(200);
        len = (AW+1)'(4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wcnt = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (avm_write) wcnt++;
            if (wcnt == 2) break;
            @(negedge clk);
        end
        checkOutput("reached second write", wcnt, 2);
        reset_n = 1'b0;
        #1;
        checkOutput("async reset outputs",
                    {busy, done, error, avm_read, avm_write, avm_address, avm_byteenable, avm_writedata}, 0);
        ref_mem[200] = ref_mem[0];
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bad_n = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (done || busy || error || avm_read || avm_write) bad_n++;
            @(negedge clk);
        end
        checkOutput("quiet after reset release", bad_n, 0);
        checkOutput("memory after abort", memDiffs(), 0);
        applyStimulus('{0, 300, 3, 0, 1'b0, 1'b0, 10}, "after_reset");

        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 3) begin
                v.src = $urandom_range(DEPTH - 10, DEPTH - 1);
                v.dst = $urandom_range(DEPTH - 12, DEPTH - 1);
                v.len = $urandom_range(0, 12);
            end else begin
                v.src = $urandom_range(0, 48);
                v.dst = $urandom_range(0, 48);
                v.len = $urandom_range(0, 8);
            end
            v.stalls   = 0;
            v.rnd      = 1'b1;
            v.exp_err  = modelRejects(v.src, v.dst, v.len);
            v.exp_busy = -1;
            applyStimulus(v, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
